reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//   Integer register file (x0..x31) of the single-cycle RV32I core, with the write-back source mux built in.
//   Supplies reg_data1/reg_data2 to the ALU operand path; reg_data2 is the register input of alu_src_mux.
//   Selects and commits the write-back value (ALU result, load data, PC+4, immediate).
//   A post-reset sweep FSM zeroes every register one per clock; ready flags when the file is usable.
// PARAMETERS
//   XLEN    32  data width of each register and of all data ports
//   NREG    32  number of architectural registers; x0 hardwired to zero
//   ADDR_W  5   register address width; must satisfy 2**ADDR_W == NREG
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous, active-low reset
//   rs1_addr    in   ADDR_W  read port 1 address
//   rs2_addr    in   ADDR_W  read port 2 address
//   rd_addr     in   ADDR_W  write address
//   reg_write   in   1       write enable from control unit
//   result_src  in   2       write-back select: 00 alu_result, 01 mem_rdata, 10 pc_plus4, 11 imm_ext
//   alu_result  in   XLEN    ALU output
//   mem_rdata   in   XLEN    data-memory load data
//   pc_plus4    in   XLEN    PC+4, for JAL/JALR link
//   imm_ext     in   XLEN    extended immediate, for LUI
//   reg_data1   out  XLEN    read data, port 1
//   reg_data2   out  XLEN    read data, port 2
//   wb_data     out  XLEN    selected write-back value (combinational)
//   ready       out  1       1 = sweep done, writes accepted
// BEHAVIOUR
//   Reset
//     - rst_n=0 asynchronously forces state=CLEAR, clr_ptr=1 and ready=0.
//     - Storage is not reset directly; the sweep zeroes it.
//   CLEAR state
//     - Each rising edge writes 0 to regs[clr_ptr] and increments clr_ptr.
//     - On the edge that clears reg NREG-1, state moves to RUN.
//     - ready=1 after the 31st rising edge following rst_n release.
//     - ready stays 0 throughout CLEAR, including on that last edge.
//   RUN state
//     - Terminal; only rst_n leaves it.
//     - Reset asserted mid-sweep or in RUN restarts the sweep from clr_ptr=1.
//   Reads
//     - Combinational, zero latency.
//     - reg_data1/2 = 0 while ready=0 and whenever the address is 0.
//     - Otherwise they show the stored register value.
//   Writes
//     - On a rising edge when ready & reg_write & (rd_addr!=0): regs[rd_addr] <= wb_data.
//     - reg_write during CLEAR is ignored; the write is dropped, not queued.
//     - rd_addr=0 is ignored; x0 always reads 0.
//   Read-during-write
//     - Same cycle, same address: reads return the OLD value.
//     - The new value is visible the cycle after the edge.
//     - There is no write-to-read bypass. It would close a combinational loop through the ALU.
//   wb_data
//     - Pure mux of result_src and is valid in every state. result_src=11 selects imm_ext.
//     - Full XLEN width; no extension or truncation.
// CONFIGURATION
//   REGFILE_DEBUG_EN
//     - Defined: adds ports dbg_addr (in, ADDR_W) and dbg_data (out, XLEN).
//     - dbg_data is a combinational third read port, independent of ready.
//     - It returns raw storage, so it shows values mid-sweep. dbg_addr=0 returns 0.
//     - Undefined: both ports are absent and there is no extra read logic.
// TESTING
//   1. Release rst_n, idle -> ready=0 for 30 edges and 1 after the 31st; reading x1..x31 then gives 0.
//   2. ready=1, rd=5, result_src=00, alu_result=32'h0000_00AA, reg_write=1
//      -> rs1=5 reads 0 in the write cycle and 32'hAA the next cycle.
//   3. Write x6/x7/x8 with result_src 01/10/11 (mem_rdata=32'h1234_5678, pc_plus4=32'h0000_0104, imm_ext=32'hFFFF_F000)
//      -> each register reads back its source value.
//   4. rd=0, alu_result=32'hDEAD_BEEF, reg_write=1 -> rs1=0 and rs2=0 both read 0.
//   5. reg_write=1, rd=3, alu_result=32'h55 at sweep edge 10 -> x3 reads 0 once ready.
//      Then assert rst_n=0 at edge 20 of a new sweep -> ready drops at once and rises 31 edges after release.
//   6. REGFILE_DEBUG_EN defined: write x9=32'h99, set dbg_addr=9 -> dbg_data=32'h99 with no clock edge.

Source files
------------

// File: rtl/reg_file_wb.sv
// RV32I integer register file with built-in write-back mux and post-reset clearing sweep.
// Optional debug read port enabled by defining REGFILE_DEBUG_EN.
module reg_file_wb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              reg_write,
  input  logic [1:0]        result_src,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [XLEN-1:0]   imm_ext,
  output logic [XLEN-1:0]   reg_data1,
  output logic [XLEN-1:0]   reg_data2,
  output logic [XLEN-1:0]   wb_data,
`ifdef REGFILE_DEBUG_EN
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
`endif
  output logic              ready
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(NREG - 1);
  localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] clr_ptr_reg, clr_ptr_next;
  logic [XLEN-1:0]   regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= FIRST_PTR;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    if (state_reg == CLEAR) begin
      clr_ptr_next = clr_ptr_reg + FIRST_PTR;
      if (clr_ptr_reg == LAST_PTR) begin
        state_next   = RUN;
        clr_ptr_next = clr_ptr_reg;
      end
    end
  end

  assign ready = (state_reg == RUN);

  always_comb begin
    wb_data = alu_result;
    case (result_src)
      2'b00:   wb_data = alu_result;
      2'b01:   wb_data = mem_rdata;
      2'b10:   wb_data = pc_plus4;
      default: wb_data = imm_ext;
    endcase
  end

  // Storage has no reset; the sweep is the only path that initialises it.
  always_ff @(posedge clk) begin
    if (state_reg == CLEAR)
      regs[clr_ptr_reg] <= '0;
    else if (reg_write && (rd_addr != '0))
      regs[rd_addr] <= wb_data;
  end

  // No write-to-read bypass: a bypass would close a loop through the ALU.
  assign reg_data1 = (ready && (rs1_addr != '0)) ? regs[rs1_addr] : '0;
  assign reg_data2 = (ready && (rs2_addr != '0)) ? regs[rs2_addr] : '0;

`ifdef REGFILE_DEBUG_EN
  assign dbg_data = (dbg_addr != '0) ? regs[dbg_addr] : '0;
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb: sweep timing, write-back sources, x0, read-during-write,
// reset restart, and the debug read port when REGFILE_DEBUG_EN is defined.
module tb_reg_file_wb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        reg_write;
  logic [1:0]  result_src;
  logic [31:0] alu_result, mem_rdata, pc_plus4, imm_ext;
  logic [31:0] reg_data1, reg_data2, wb_data;
  logic        ready;
`ifdef REGFILE_DEBUG_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_wb dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .reg_write(reg_write), .result_src(result_src),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4), .imm_ext(imm_ext),
    .reg_data1(reg_data1), .reg_data2(reg_data2), .wb_data(wb_data),
`ifdef REGFILE_DEBUG_EN
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
`endif
    .ready(ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Steps from just after a posedge: waits one edge and samples 1 time unit later.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Releases reset and checks ready over the 31-edge sweep; optionally attempts a write at one edge.
  task automatic release_and_sweep(input string tag, input int write_edge);
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      if (i == write_edge) begin
        rd_addr = 5'd3; result_src = 2'b00; alu_result = 32'h55; reg_write = 1'b1;
      end
      edge_step();
      reg_write = 1'b0;
      chk($sformatf("%s_ready_e%0d", tag, i), {31'b0, ready}, (i == 31) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [1:0] src);
    rd_addr = rd; result_src = src; reg_write = 1'b1;
    edge_step();
    reg_write = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rs1_addr = '0; rs2_addr = '0; rd_addr = '0; reg_write = 1'b0;
    result_src = 2'b00; alu_result = '0; mem_rdata = '0; pc_plus4 = '0; imm_ext = '0;
`ifdef REGFILE_DEBUG_EN
    dbg_addr = '0;
`endif
    repeat (3) edge_step();
    chk("reset_ready", {31'b0, ready}, 32'd0);
    rs1_addr = 5'd7;
    #1;
    chk("reset_rd1", reg_data1, 32'd0);

    // 1: sweep timing and cleared contents
    release_and_sweep("sweep1", 0);
    for (int r = 1; r < 32; r++) begin
      rs1_addr = 5'(r); rs2_addr = 5'(32 - r);
      #1;
      chk($sformatf("clear_rd1_x%0d", r), reg_data1, 32'd0);
      chk($sformatf("clear_rd2_x%0d", 32 - r), reg_data2, 32'd0);
    end

    // 2: write x5 from ALU; old value during write cycle, new value after
    rs1_addr = 5'd5; rd_addr = 5'd5; result_src = 2'b00; alu_result = 32'h0000_00AA; reg_write = 1'b1;
    #1;
    chk("wb_alu", wb_data, 32'h0000_00AA);
    chk("rdw_old", reg_data1, 32'd0);
    edge_step();
    reg_write = 1'b0;
    chk("rdw_new", reg_data1, 32'h0000_00AA);

    // 3: other write-back sources
    mem_rdata = 32'h1234_5678; pc_plus4 = 32'h0000_0104; imm_ext = 32'hFFFF_F000;
    write_reg(5'd6, 2'b01);
    write_reg(5'd7, 2'b10);
    write_reg(5'd8, 2'b11);
    rs1_addr = 5'd6; rs2_addr = 5'd7; #1;
    chk("x6_mem", reg_data1, 32'h1234_5678);
    chk("x7_pc4", reg_data2, 32'h0000_0104);
    rs1_addr = 5'd8; rs2_addr = 5'd5; #1;
    chk("x8_imm", reg_data1, 32'hFFFF_F000);
    chk("x5_kept", reg_data2, 32'h0000_00AA);

    // 4: x0 writes are ignored
    alu_result = 32'hDEAD_BEEF;
    write_reg(5'd0, 2'b00);
    rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
    chk("x0_rd1", reg_data1, 32'd0);
    chk("x0_rd2", reg_data2, 32'd0);
    rs1_addr = 5'd5; #1;
    chk("x5_after_x0", reg_data1, 32'h0000_00AA);

`ifdef REGFILE_DEBUG_EN
    // 6: debug port reads storage without a clock edge
    alu_result = 32'h99;
    write_reg(5'd9, 2'b00);
    #2;
    dbg_addr = 5'd9; #1;
    chk("dbg_x9", dbg_data, 32'h99);
    dbg_addr = 5'd0; #1;
    chk("dbg_x0", dbg_data, 32'd0);
`endif

    // 5: async reset in RUN, write attempted mid-sweep is dropped
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ready_drop", {31'b0, ready}, 32'd0);
    rs1_addr = 5'd5; #1;
    chk("reset_rd_masked", reg_data1, 32'd0);
    edge_step();
    release_and_sweep("sweep2", 10);
    rs1_addr = 5'd3; rs2_addr = 5'd5; #1;
    chk("sweep_write_dropped", reg_data1, 32'd0);
    chk("x5_cleared", reg_data2, 32'd0);

    // 5b: reset asserted at edge 20 of a new sweep restarts it
    rst_n = 1'b0;
    edge_step();
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) edge_step();
    rst_n = 1'b0;
    #1;
    chk("midsweep_ready", {31'b0, ready}, 32'd0);
    edge_step();
    release_and_sweep("sweep3", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
